// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Purpose  : Bundles the fetch requester, load/store requester and memory
//             port signals of the memory port arbiter.
//             slave  = arbiter side, master = requester/memory side.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // instruction fetch requester
    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_resp_valid;
    logic [DATA_WIDTH-1:0] if_resp_data;
    // load/store requester
    logic                  d_req_valid;
    logic                  d_req_ready;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [2:0]            d_bytes;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_resp_valid;
    logic [DATA_WIDTH-1:0] d_resp_data;
    logic                  d_resp_err;
    // single memory port
    logic                  mem_valid;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [2:0]            mem_bytes_to_write;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req_valid, if_addr, d_req_valid, d_addr, d_bytes, d_wdata, mem_rdata,
        output if_req_ready, if_resp_valid, if_resp_data,
               d_req_ready, d_resp_valid, d_resp_data, d_resp_err,
               mem_valid, mem_addr, mem_bytes_to_write, mem_write_data
    );

    modport master (
        output if_req_valid, if_addr, d_req_valid, d_addr, d_bytes, d_wdata, mem_rdata,
        input  if_req_ready, if_resp_valid, if_resp_data,
               d_req_ready, d_resp_valid, d_resp_data, d_resp_err,
               mem_valid, mem_addr, mem_bytes_to_write, mem_write_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one memory port between instruction fetch and load/store.
//             One access in flight; data has priority, a starvation counter
//             forces a fetch grant after STARVE_LIMIT consecutive data grants.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input wire                clk,
    input wire                rst,
    mem_port_arbiter_if.slave bus
);

    localparam int c_cnt_w    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int c_starve_w = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [c_cnt_w-1:0]    c_lat_load   = c_cnt_w'(MEM_LATENCY - 1);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                  state_q,  state_d;
    logic                    owner_q,  owner_d;   // 1 = load/store, 0 = fetch
    logic [ADDR_WIDTH-1:0]   addr_q,   addr_d;
    logic [2:0]              bytes_q,  bytes_d;   // bytes to write, 0 = read
    logic [DATA_WIDTH-1:0]   wdata_q,  wdata_d;
    logic                    err_q,    err_d;
    logic [c_cnt_w-1:0]      cnt_q,    cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q,  rdata_d;
    logic [c_starve_w-1:0]   starve_q, starve_d;

    logic d_grant;
    logic if_grant;
    logic d_legal;

    // State register and latched access fields
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            addr_q   <= '0;
            bytes_q  <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            bytes_q  <= bytes_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            starve_q <= starve_d;
        end
    end

    // Arbitration, next-state logic and all port outputs
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        bytes_d  = bytes_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        starve_d = starve_q;
        d_grant  = 1'b0;
        if_grant = 1'b0;
        d_legal  = bus.d_bytes inside {3'd0, 3'd1, 3'd2, 3'd4};

        bus.if_req_ready       = 1'b0;
        bus.if_resp_valid      = 1'b0;
        bus.if_resp_data       = '0;
        bus.d_req_ready        = 1'b0;
        bus.d_resp_valid       = 1'b0;
        bus.d_resp_data        = '0;
        bus.d_resp_err         = 1'b0;
        bus.mem_valid          = 1'b0;
        bus.mem_addr           = '0;
        bus.mem_bytes_to_write = '0;
        bus.mem_write_data     = '0;

        case (state_q)
            ST_IDLE: begin
                // Data wins unless fetch has waited through STARVE_LIMIT data grants
                d_grant  = bus.d_req_valid &
                           ~(bus.if_req_valid & (starve_q == c_starve_max));
                if_grant = bus.if_req_valid & ~d_grant;
                if (d_grant) begin
                    owner_d = 1'b1;
                    addr_d  = bus.d_addr;
                    err_d   = ~d_legal;
                    bytes_d = d_legal ? bus.d_bytes : 3'd0;
                    wdata_d = bus.d_wdata;
                    state_d = ST_ISSUE;
                    if (bus.if_req_valid && (starve_q != c_starve_max)) begin
                        starve_d = starve_q + c_starve_w'(1);
                    end
                end else if (if_grant) begin
                    owner_d  = 1'b0;
                    addr_d   = bus.if_addr;
                    err_d    = 1'b0;
                    bytes_d  = 3'd0;
                    wdata_d  = '0;
                    starve_d = '0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = c_lat_load;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    // Only plain reads return data; stores and bad sizes return 0
                    rdata_d = ((bytes_q == 3'd0) && !err_q) ? bus.mem_rdata : '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - c_cnt_w'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are held at zero for the whole cycle while reset is asserted
        if (!rst) begin
            bus.if_req_ready = if_grant;
            bus.d_req_ready  = d_grant;
            if (state_q == ST_ISSUE) begin
                bus.mem_valid          = 1'b1;
                bus.mem_addr           = addr_q;
                bus.mem_bytes_to_write = bytes_q;
                bus.mem_write_data     = (bytes_q != 3'd0) ? wdata_q : '0;
            end
            if (state_q == ST_RESP) begin
                if (owner_q) begin
                    bus.d_resp_valid = 1'b1;
                    bus.d_resp_data  = rdata_q;
                    bus.d_resp_err   = err_q;
                end else begin
                    bus.if_resp_valid = 1'b1;
                    bus.if_resp_data  = rdata_q;
                end
            end
        end
    end

endmodule
`default_nettype wire
